// File: rtl/vec_pkg.sv
// Shared vector register file constants, types and address range helper.
// Physical indices arrive 5 bits wide; only 0..NVREGS-1 name real vector registers.
package vec_pkg;
    localparam int LANES  = 4;
    localparam int ELEM_W = 8;
    localparam int NVREGS = 8;
    localparam int VREG_W = LANES * ELEM_W;
    localparam int IDX_W  = $clog2(NVREGS);

    typedef logic [VREG_W-1:0] vreg_t;
    typedef logic [4:0]        vidx_t;

    function automatic logic in_range(input vidx_t idx);
        return idx < vidx_t'(NVREGS);
    endfunction
endpackage

// File: rtl/vec_scoreboard.sv
// Vector scoreboard: pending-producer mask plus RAW/WAW hazard stall.
// Latency: stall is combinational, busy_mask updates at the next posedge.
// Backpressure: stall is the backpressure to decode; a stalled issue reserves nothing.
module vec_scoreboard
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              rd1_en,
    input  logic [4:0]        rd1_addr,
    input  logic              rd2_en,
    input  logic [4:0]        rd2_addr,
    input  logic              rdst_en,
    input  logic [4:0]        rdst_addr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    output logic              stall,
    output logic              hit1,
    output logic              hit2,
    output logic [NVREGS-1:0] busy_mask
);
    logic              hitd;
    logic              wb_ok;
    logic              raw1;
    logic              raw2;
    logic              waw;
    logic [NVREGS-1:0] busy_nxt;

    assign wb_ok = wb_en && in_range(wb_addr);
    assign hit1  = wb_ok && (wb_addr == rd1_addr);
    assign hit2  = wb_ok && (wb_addr == rd2_addr);
    assign hitd  = wb_ok && (wb_addr == rdst_addr);

    // Out-of-range indices name scalar registers and never hazard.
    assign raw1  = rd1_en  && in_range(rd1_addr)  && busy_mask[rd1_addr[IDX_W-1:0]]  && !hit1;
    assign raw2  = rd2_en  && in_range(rd2_addr)  && busy_mask[rd2_addr[IDX_W-1:0]]  && !hit2;
    assign waw   = rdst_en && in_range(rdst_addr) && busy_mask[rdst_addr[IDX_W-1:0]] && !hitd;
    assign stall = issue && (raw1 || raw2 || waw);

    always_comb begin
        busy_nxt = busy_mask;
        if (wb_ok)
            busy_nxt[wb_addr[IDX_W-1:0]] = 1'b0;
        // Applied after the clear so a new producer keeps the bit set.
        if (issue && !stall && rdst_en && in_range(rdst_addr))
            busy_nxt[rdst_addr[IDX_W-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_mask <= '0;
        else
            busy_mask <= busy_nxt;
    end
endmodule

// File: rtl/vec_regfile_sb.sv
// Vector register file with writeback bypass, registered operands and scoreboard.
// Latency: operands valid 1 cycle after accept; writeback visible to same-cycle reads.
// Backpressure: combinational stall holds decode; stalled cycles produce a bubble.
module vec_regfile_sb
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rd1_en,
    input  logic [4:0]        rd1_addr,
    input  logic              rd2_en,
    input  logic [4:0]        rd2_addr,
    input  logic              rdst_en,
    input  logic [4:0]        rdst_addr,
    input  logic              issue,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [VREG_W-1:0] wb_data,
    output logic              stall,
    output logic              out_valid,
    output logic [VREG_W-1:0] rd1_data,
    output logic [VREG_W-1:0] rd2_data,
    output logic [NVREGS-1:0] busy_mask,
    output logic              addr_err
);
    vreg_t regs [NVREGS];
    vreg_t op1;
    vreg_t op2;
    logic  hit1;
    logic  hit2;
    logic  accept;
    logic  bad_addr;

    vec_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .rd1_en    (rd1_en),
        .rd1_addr  (rd1_addr),
        .rd2_en    (rd2_en),
        .rd2_addr  (rd2_addr),
        .rdst_en   (rdst_en),
        .rdst_addr (rdst_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .stall     (stall),
        .hit1      (hit1),
        .hit2      (hit2),
        .busy_mask (busy_mask)
    );

    assign accept = issue && !stall;

    always_comb begin
        op1 = '0;
        op2 = '0;
        if (rd1_en && in_range(rd1_addr))
            op1 = hit1 ? wb_data : regs[rd1_addr[IDX_W-1:0]];
        if (rd2_en && in_range(rd2_addr))
            op2 = hit2 ? wb_data : regs[rd2_addr[IDX_W-1:0]];
    end

    // Read/dest garbage only matters when decode presents an instruction.
    assign bad_addr = (issue && ((rd1_en  && !in_range(rd1_addr)) ||
                                 (rd2_en  && !in_range(rd2_addr)) ||
                                 (rdst_en && !in_range(rdst_addr)))) ||
                      (wb_en && !in_range(wb_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NVREGS; i++)
                regs[i] <= '0;
        end else if (wb_en && in_range(wb_addr)) begin
            regs[wb_addr[IDX_W-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            rd1_data  <= '0;
            rd2_data  <= '0;
            addr_err  <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                rd1_data <= op1;
                rd2_data <= op2;
            end
            addr_err <= addr_err || bad_addr;
        end
    end
endmodule

// File: tb/tb_vec_regfile_sb.sv
// Directed bench for vec_regfile_sb: reset, bypass, RAW/WAW stall, reserve priority, addr_err.
// Inputs change 1ns after posedge; outputs are sampled there too, away from the edge.
module tb_vec_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd1_en, rd2_en, rdst_en, issue, wb_en;
    logic [4:0]  rd1_addr, rd2_addr, rdst_addr, wb_addr;
    logic [31:0] wb_data;
    logic        stall, out_valid, addr_err;
    logic [31:0] rd1_data, rd2_data;
    logic [7:0]  busy_mask;

    int checks   = 0;
    int failures = 0;

    vec_regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rd1_en    (rd1_en),
        .rd1_addr  (rd1_addr),
        .rd2_en    (rd2_en),
        .rd2_addr  (rd2_addr),
        .rdst_en   (rdst_en),
        .rdst_addr (rdst_addr),
        .issue     (issue),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall     (stall),
        .out_valid (out_valid),
        .rd1_data  (rd1_data),
        .rd2_data  (rd2_data),
        .busy_mask (busy_mask),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue = 0; rd1_en = 0; rd2_en = 0; rdst_en = 0; wb_en = 0;
        rd1_addr = 0; rd2_addr = 0; rdst_addr = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic iss(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                       input logic ed, input logic [4:0] ad);
        issue = 1; rd1_en = e1; rd1_addr = a1; rd2_en = e2; rd2_addr = a2;
        rdst_en = ed; rdst_addr = ad;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();

        // Dirty every output, then reset between edges.
        wb(6, 32'hDEADBEEF);
        iss(1, 6, 1, 12, 1, 7);
        tick();
        idle();
        chk("pre_valid", 32'(out_valid), 32'h1);
        chk("pre_rd1_bypass", rd1_data, 32'hDEADBEEF);
        chk("pre_busy", 32'(busy_mask), 32'h80);
        chk("pre_addr_err", 32'(addr_err), 32'h1);
        #3 rst = 1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_rd1", rd1_data, 32'h0);
        chk("rst_rd2", rd2_data, 32'h0);
        chk("rst_busy", 32'(busy_mask), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1 rst = 0;

        iss(1, 0, 1, 1, 0, 0);
        tick();
        idle();
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_rd1", rd1_data, 32'h0);
        chk("t1_rd2", rd2_data, 32'h0);
        chk("t1_busy", 32'(busy_mask), 32'h0);
        tick();
        chk("idle_valid", 32'(out_valid), 32'h0);

        wb(3, 32'h01020304);
        tick();
        idle();
        iss(1, 3, 0, 0, 0, 0);
        #1 chk("t2_stall", 32'(stall), 32'h0);
        tick();
        idle();
        chk("t2_rd1", rd1_data, 32'h01020304);

        wb(5, 32'hAABBCCDD);
        iss(0, 0, 1, 5, 0, 0);
        tick();
        idle();
        chk("t3_rd2_bypass", rd2_data, 32'hAABBCCDD);
        chk("t3_rd1_disabled", rd1_data, 32'h0);
        iss(1, 5, 1, 6, 0, 0);
        tick();
        idle();
        chk("t3_rd1_reg5", rd1_data, 32'hAABBCCDD);
        chk("t3_rd2_reg6_cleared", rd2_data, 32'h0);

        iss(1, 3, 0, 0, 1, 2);
        tick();
        idle();
        chk("t4_busy_set", 32'(busy_mask), 32'h04);
        chk("t4_rd1", rd1_data, 32'h01020304);
        iss(1, 2, 0, 0, 0, 0);
        #1 chk("t4_raw_stall", 32'(stall), 32'h1);
        tick();
        chk("t4_bubble", 32'(out_valid), 32'h0);
        chk("t4_rd1_hold", rd1_data, 32'h01020304);
        chk("t4_busy_kept", 32'(busy_mask), 32'h04);
        wb(2, 32'h11223344);
        #1 chk("t4_clear_stall", 32'(stall), 32'h0);
        tick();
        idle();
        chk("t4_rd1_bypass", rd1_data, 32'h11223344);
        chk("t4_busy_clear", 32'(busy_mask), 32'h0);
        chk("t4_valid", 32'(out_valid), 32'h1);

        iss(0, 0, 0, 0, 1, 4);
        tick();
        idle();
        chk("t5_busy4", 32'(busy_mask), 32'h10);
        wb(4, 32'h55667788);
        iss(1, 4, 0, 0, 1, 4);
        #1 chk("t5_waw_stall", 32'(stall), 32'h0);
        tick();
        idle();
        chk("t5_busy_kept", 32'(busy_mask), 32'h10);
        chk("t5_rd1", rd1_data, 32'h55667788);
        iss(0, 0, 1, 4, 0, 0);
        #1 chk("t5_raw_new_producer", 32'(stall), 32'h1);
        idle();
        wb(4, 32'h99AABBCC);
        tick();
        idle();
        chk("t5_busy_drained", 32'(busy_mask), 32'h0);
        iss(0, 0, 1, 4, 0, 0);
        tick();
        idle();
        chk("t5_reg4", rd2_data, 32'h99AABBCC);

        iss(1, 9, 0, 0, 1, 9);
        #1 chk("t6_stall", 32'(stall), 32'h0);
        tick();
        idle();
        chk("t6_rd1_zero", rd1_data, 32'h0);
        chk("t6_addr_err", 32'(addr_err), 32'h1);
        chk("t6_no_reserve", 32'(busy_mask), 32'h0);
        chk("t6_valid", 32'(out_valid), 32'h1);
        for (int i = 0; i < 10; i++) tick();
        chk("t6_addr_err_held", 32'(addr_err), 32'h1);
        rst = 1;
        #1 chk("t6_addr_err_rst", 32'(addr_err), 32'h0);
        tick();
        rst = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
